line_tracker_ctrl: RTL
======================

// Module: line_tracker_ctrl
// PURPOSE
//  Upstream decision stage of the motor path: converts three IR line-sensor bits into
//  the 3-bit drive mode consumed by the motor/PWM block. Synchronises and debounces
//  sensors, runs a steering FSM, ramps straight-line speed and recovers or halts on
//  line loss. Mode output is registered and changes at most once per debounced event.
// PARAMETERS
//  DEBOUNCE_CYCLES  100_000      cycles a synced sensor pattern must hold before accepted (>=1)
//  RAMP_CYCLES      50_000_000   cycles in STRAIGHT per speed-level step (1->2->3)
//  LOST_TIMEOUT     200_000_000  cycles in LOST before entering HALT
// PORTS
//  clk        in   1  system clock, 100 MHz
//  rst        in   1  synchronous, active-high reset
//  start      in   1  run enable; low forces IDLE (mode STOP)
//  sensor     in   3  {L,M,R} raw IR bits, 1 = line seen; asynchronous to clk
//  mode       out  3  drive mode to motor stage (encodings below)
//  lost       out  1  high while in LOST or HALT
//  state_dbg  out  3  current FSM state code
// BEHAVIOUR
//  Mode codes: STOP=000 S1=001 S2=010 S3=011 L1=100 (in place) L2=101 (arc)
//   R1=110 (in place) R2=111 (arc).
//  Reset: mode=STOP, lost=0, state=IDLE, filt=000, speed level=1, all counters=0.
//  Input path: 2-FF synchroniser -> filter. Candidate register + counter; counter clears
//   whenever synced value != candidate; when counter reaches DEBOUNCE_CYCLES-1 with a
//   match, filt<=candidate. Pattern stable from cycle t reaches filt at t+2+DEBOUNCE_CYCLES,
//   mode at t+3+DEBOUNCE_CYCLES (fixed, verifiable latency).
//  States: IDLE=0 STRAIGHT=1 LEFT=2 RIGHT=3 LOST=4 HALT=5.
//  start=0 in any state -> IDLE next cycle, mode=STOP; overrides all other transitions.
//  IDLE: start=1 -> state chosen from filt per table below.
//  Decision table on filt (evaluated each cycle in STRAIGHT/LEFT/RIGHT/LOST):
//   010 -> STRAIGHT, mode=S<level>      111 -> STRAIGHT, level forced to 1 (intersection)
//   110 -> LEFT, mode=L2                100 -> LEFT, mode=L1
//   011 -> RIGHT, mode=R2               001 -> RIGHT, mode=R1
//   000 -> LOST                         101 -> invalid: hold state and mode unchanged
//  Speed ramp: entering STRAIGHT from any other state sets level=1 and clears ramp counter;
//   every RAMP_CYCLES in STRAIGHT level increments, saturating at 3 (no wrap).
//  LOST: mode = L1 if last turn state was LEFT, R1 if RIGHT, S1 if STRAIGHT/none; timeout
//   counter cleared on entry; any non-000, non-101 filt exits per table; reaching
//   LOST_TIMEOUT -> HALT.
//  HALT: mode=STOP, lost=1; exits only via start=0 -> IDLE (sensors ignored).
//  Simultaneous: start=0 beats timeout and sensor change; timeout expiry and filt update
//   in same cycle -> filt update wins (line reacquired).
//  rst mid-operation returns all state to reset values next edge; filter restarts.
//  Counters sized $clog2(param+1); no overflow; comparisons unsigned.
// STRUCTURE
//  Shared header motor_defs.vh: mode code localparams (shared with motor stage), FSM
//   state codes. Sub-module sensor_debounce (sync + filter, DEBOUNCE_CYCLES param,
//   outputs filt[2:0]). FSM, ramp and timeout counters in top.
// TESTING (bench overrides DEBOUNCE_CYCLES=4, RAMP_CYCLES=16, LOST_TIMEOUT=32)
//  1 rst, start=1, sensor=010 held -> mode=001 exactly 7 cycles after sensor set;
//    S2 16 cycles later, S3 after 16 more, stays 011.
//  2 sensor 010 with 3-cycle glitch to 100 -> mode never leaves S-codes; 5-cycle 100 -> 100.
//  3 sequence 110 -> 011 -> 001 -> 111 -> expect 101,111,110, then 001 (level reset).
//  4 from RIGHT, sensor=000 -> mode=110, lost=1; after 32 cycles mode=000, state=HALT;
//    sensor=010 ignored; start 0->1 -> STRAIGHT mode=001.
//  5 sensor=101 while in LEFT(L2) -> mode stays 101; start=0 mid-ramp -> mode=000 next cycle.
//  6 assert rst during STRAIGHT level 3 -> next cycle mode=000, state_dbg=0, lost=0.

Source files
------------

// File: rtl/line_tracker_ctrl_pkg.sv
// Shared definitions for the line tracker: drive-mode codes (common with the motor stage),
// FSM state codes and the sensor decision table.
package line_tracker_ctrl_pkg;

  localparam int SENSOR_W = 3;

  localparam logic [2:0] MODE_STOP = 3'b000;
  localparam logic [2:0] MODE_S1   = 3'b001;
  localparam logic [2:0] MODE_S2   = 3'b010;
  localparam logic [2:0] MODE_S3   = 3'b011;
  localparam logic [2:0] MODE_L1   = 3'b100;
  localparam logic [2:0] MODE_L2   = 3'b101;
  localparam logic [2:0] MODE_R1   = 3'b110;
  localparam logic [2:0] MODE_R2   = 3'b111;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_STRAIGHT = 3'd1;
  localparam logic [2:0] ST_LEFT     = 3'd2;
  localparam logic [2:0] ST_RIGHT    = 3'd3;
  localparam logic [2:0] ST_LOST     = 3'd4;
  localparam logic [2:0] ST_HALT     = 3'd5;

  typedef struct packed {
    logic       valid;  // 0 for the physically impossible 101 pattern
    logic [2:0] state;
    logic [2:0] mode;   // turn mode; straight speed comes from the ramp level
  } decision_t;

  function automatic decision_t decode_line(input logic [SENSOR_W-1:0] filt);
    decision_t d;
    d.valid = 1'b1;
    d.state = ST_STRAIGHT;
    d.mode  = MODE_S1;
    case (filt)
      3'b010, 3'b111: ;
      3'b110: begin d.state = ST_LEFT;  d.mode = MODE_L2; end
      3'b100: begin d.state = ST_LEFT;  d.mode = MODE_L1; end
      3'b011: begin d.state = ST_RIGHT; d.mode = MODE_R2; end
      3'b001: begin d.state = ST_RIGHT; d.mode = MODE_R1; end
      3'b000: d.state = ST_LOST;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] speed_mode(input logic [1:0] level);
    return {1'b0, level};
  endfunction

  // Search direction while the line is lost follows the last steering state.
  function automatic logic [2:0] lost_mode(input logic [2:0] prev_state);
    case (prev_state)
      ST_LEFT:  return MODE_L1;
      ST_RIGHT: return MODE_R1;
      default:  return MODE_S1;
    endcase
  endfunction

endpackage

// File: rtl/line_tracker_ctrl_sensor_debounce.sv
// Two-flop synchroniser followed by a hold-time filter for the three IR line sensors.
module sensor_debounce
  import line_tracker_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SENSOR_W-1:0] i_sensor,
  output logic [SENSOR_W-1:0] o_filt
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SENSOR_W-1:0] r_sync1;
  logic [SENSOR_W-1:0] r_sync2;
  logic [SENSOR_W-1:0] r_cand;
  logic [SENSOR_W-1:0] r_filt;
  logic [CNT_W-1:0]    r_cnt;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_cand  <= '0;
      r_filt  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_sensor;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_cand) begin
        r_cand <= r_sync2;
        r_cnt  <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_filt <= r_cand;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_filt = r_filt;

endmodule

// File: rtl/line_tracker_ctrl.sv
// Line tracker decision stage: debounced sensors drive a steering FSM with a straight-line
// speed ramp and a lost-line search that halts after a timeout.
module line_tracker_ctrl
  import line_tracker_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int RAMP_CYCLES     = 50_000_000,
  parameter int LOST_TIMEOUT    = 200_000_000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [SENSOR_W-1:0] sensor,
  output logic [2:0]          mode,
  output logic                lost,
  output logic [2:0]          state_dbg
);

  localparam int               RAMP_W    = $clog2(RAMP_CYCLES + 1);
  localparam int               LOST_W    = $clog2(LOST_TIMEOUT + 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_LAST = LOST_W'(LOST_TIMEOUT - 1);

  logic [SENSOR_W-1:0] w_filt;
  decision_t           w_dec;

  logic [2:0]        r_state,    w_state_nxt;
  logic [2:0]        r_mode,     w_mode_nxt;
  logic              r_lost,     w_lost_nxt;
  logic [1:0]        r_level,    w_level_nxt;
  logic [RAMP_W-1:0] r_ramp_cnt, w_ramp_nxt;
  logic [LOST_W-1:0] r_lost_cnt, w_lost_cnt_nxt;
  logic              w_take;

  sensor_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .i_sensor (sensor),
    .o_filt   (w_filt)
  );

  assign w_dec = decode_line(w_filt);

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_lost_nxt     = r_lost;
    w_level_nxt    = r_level;
    w_ramp_nxt     = r_ramp_cnt;
    w_lost_cnt_nxt = r_lost_cnt;
    w_take         = 1'b0;

    case (r_state)
      // IDLE waits for an actual line before leaving; an all-dark filter keeps the robot stopped.
      ST_IDLE: w_take = w_dec.valid && (w_dec.state != ST_LOST);
      ST_STRAIGHT, ST_LEFT, ST_RIGHT: begin
        if (w_dec.valid && (w_dec.state == ST_LOST)) begin
          w_state_nxt    = ST_LOST;
          w_mode_nxt     = lost_mode(r_state);
          w_lost_nxt     = 1'b1;
          w_lost_cnt_nxt = '0;
        end else begin
          w_take = w_dec.valid;
        end
      end
      ST_LOST: begin
        if (w_dec.valid && (w_dec.state != ST_LOST)) begin
          w_take = 1'b1;
        end else if (r_lost_cnt == LOST_LAST) begin
          w_state_nxt = ST_HALT;
          w_mode_nxt  = MODE_STOP;
        end else begin
          w_lost_cnt_nxt = r_lost_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    if (w_take) begin
      w_state_nxt = w_dec.state;
      w_lost_nxt  = 1'b0;
      if (w_dec.state != ST_STRAIGHT) begin
        w_mode_nxt = w_dec.mode;
      end else begin
        // Fresh entry or an intersection restarts the ramp from the slowest speed.
        if ((r_state != ST_STRAIGHT) || (w_filt == 3'b111)) begin
          w_level_nxt = 2'd1;
          w_ramp_nxt  = '0;
        end else if (r_ramp_cnt == RAMP_LAST) begin
          w_ramp_nxt  = '0;
          w_level_nxt = (r_level == 2'd3) ? 2'd3 : r_level + 2'd1;
        end else begin
          w_ramp_nxt = r_ramp_cnt + 1'b1;
        end
        w_mode_nxt = speed_mode(w_level_nxt);
      end
    end

    if (!start) begin
      w_state_nxt    = ST_IDLE;
      w_mode_nxt     = MODE_STOP;
      w_lost_nxt     = 1'b0;
      w_level_nxt    = 2'd1;
      w_ramp_nxt     = '0;
      w_lost_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mode     <= MODE_STOP;
      r_lost     <= 1'b0;
      r_level    <= 2'd1;
      r_ramp_cnt <= '0;
      r_lost_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_lost     <= w_lost_nxt;
      r_level    <= w_level_nxt;
      r_ramp_cnt <= w_ramp_nxt;
      r_lost_cnt <= w_lost_cnt_nxt;
    end
  end

  assign mode      = r_mode;
  assign lost      = r_lost;
  assign state_dbg = r_state;

endmodule
